result_1: RTL and testbench
===========================

Name: result_1

Overview:
- Final magnitude stage of the Sobel edge-detection datapath.
- Takes the signed horizontal (gx) and vertical (gy) gradient sums for one pixel and forms the L1 magnitude |gx| + |gy|.
- Saturates the magnitude to an 8-bit pixel intensity, registers it, and flags an edge when the result meets a threshold.
- Sits after the convolution stage and before the output pixel buffer.

Parameters:
- IN_WIDTH, 11, width of each two's-complement gradient input.
- OUT_WIDTH, 8, width of the unsigned output pixel; saturation ceiling is 2^OUT_WIDTH-1 (255).
- EDGE_THRESH, 128, minimum final_out value for which edge_out is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  gx_out_1/gy_out_1 hold a valid pixel gradient pair this cycle.
- gx_out_1  input  IN_WIDTH  signed horizontal gradient, two's complement.
- gy_out_1  input  IN_WIDTH  signed vertical gradient, two's complement.
- final_out_1  output  OUT_WIDTH  saturated unsigned magnitude, registered.
- out_valid  output  1  final_out_1/edge_out valid for the current cycle.
- edge_out  output  1  final_out_1 >= EDGE_THRESH, registered alongside final_out_1.

Behaviour:
- Reset (reset=1 at a rising edge): final_out_1=0, out_valid=0, edge_out=0. Reset overrides in_valid in the same cycle. A pixel presented during reset is discarded.
- Absolute value: abs = (x<0) ? -x : x, computed as unsigned IN_WIDTH bits. The most negative input (-1024) maps to 1024 with no overflow.
- Sum: mag = abs(gx) + abs(gy) at IN_WIDTH+1 bits (12 bits, max 2048), with no wrap-around.
- Saturation: if mag > 255, the result is 255; otherwise the result is mag[7:0].
- Latency: 1 cycle. Inputs sampled at rising edge N with in_valid=1 appear on final_out_1 and edge_out after edge N, with out_valid=1.
- Hold: when in_valid=0 at an edge, out_valid goes to 0 and final_out_1/edge_out hold their previous values.
- Throughput: one pixel per cycle; back-to-back in_valid is supported with no bubbles.
- No combinational path from inputs to outputs.
- Threshold compare: edge_out is computed on the saturated 8-bit value. At the boundary, final_out_1 == EDGE_THRESH gives edge_out=1.
- X/unknown inputs with in_valid=0 must not disturb the held outputs.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, gx=50, gy=50 -> final_out_1=0, out_valid=0, edge_out=0 throughout.
- Saturation, positive inputs: gx=200, gy=112, in_valid=1 -> next cycle final_out_1=255, out_valid=1, edge_out=1.
- Negative gx with saturation: gx=-262, gy=136 -> final_out_1=255. Then gx=-1024, gy=-1024 -> 255, with no wrap.
- Non-saturating and sign-symmetry cases:
  - gx=-30, gy=20 -> 50, edge_out=0.
  - gx=100, gy=27 -> 127, edge_out=0.
  - gx=100, gy=28 -> 128, edge_out=1.
  - gx=0, gy=0 -> 0.
- Boundary: gx=255, gy=0 -> 255. gx=-128, gy=-128 -> 255 (256 saturates). gx=128, gy=127 -> 255.
- Hold and stream:
  - Drive 4 consecutive valid pairs -> 4 consecutive matching outputs.
  - Then in_valid=0 with gx=500 -> out_valid=0 and final_out_1 holds the last value.
  - Asserting reset mid-stream -> outputs 0 on the next edge.

Source files
------------

// File: rtl/result_1.sv
// Sobel magnitude stage: L1 norm |gx| + |gy| of a signed gradient pair,
// saturated to an unsigned pixel, registered with an edge flag.
module result_1 #(
    parameter int IN_WIDTH    = 11,
    parameter int OUT_WIDTH   = 8,
    parameter int EDGE_THRESH = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  gx_out_1,
    input  logic [IN_WIDTH-1:0]  gy_out_1,
    output logic [OUT_WIDTH-1:0] final_out_1,
    output logic                 out_valid,
    output logic                 edge_out
);

    localparam int                   SAT_MAX_INT = (1 << OUT_WIDTH) - 1;
    localparam logic [IN_WIDTH:0]    SAT_MAX     = SAT_MAX_INT[IN_WIDTH:0];
    localparam logic [OUT_WIDTH-1:0] THRESH      = EDGE_THRESH[OUT_WIDTH-1:0];
    localparam logic [IN_WIDTH-1:0]  ONE_IN      = {{(IN_WIDTH-1){1'b0}}, 1'b1};

    // The unsigned result keeps the full range, so the most negative input maps to 2^(IN_WIDTH-1).
    function automatic logic [IN_WIDTH-1:0] abs_val(input logic [IN_WIDTH-1:0] x);
        logic [IN_WIDTH-1:0] r;
        if (x[IN_WIDTH-1]) begin
            r = ~x + ONE_IN;
        end else begin
            r = x;
        end
        return r;
    endfunction

    logic [IN_WIDTH:0]    mag_s;
    logic [OUT_WIDTH-1:0] sat_s;
    logic                 edge_s;
    logic [OUT_WIDTH-1:0] final_d, final_q;
    logic                 valid_d, valid_q;
    logic                 edge_d,  edge_q;

    // Magnitude, saturation and threshold; hold registered values when no pixel is offered.
    always_comb begin
        mag_s   = {1'b0, abs_val(gx_out_1)} + {1'b0, abs_val(gy_out_1)};
        sat_s   = {OUT_WIDTH{1'b0}};
        edge_s  = 1'b0;
        final_d = final_q;
        edge_d  = edge_q;
        valid_d = in_valid;
        if (mag_s > SAT_MAX) begin
            sat_s = {OUT_WIDTH{1'b1}};
        end else begin
            sat_s = mag_s[OUT_WIDTH-1:0];
        end
        edge_s = (sat_s >= THRESH);
        if (in_valid) begin
            final_d = sat_s;
            edge_d  = edge_s;
        end else begin
            final_d = final_q;
            edge_d  = edge_q;
        end
    end

    // Output registers; reset takes priority over a pixel offered in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            final_q <= {OUT_WIDTH{1'b0}};
            valid_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            final_q <= final_d;
            valid_q <= valid_d;
            edge_q  <= edge_d;
        end
    end

    assign final_out_1 = final_q;
    assign out_valid   = valid_q;
    assign edge_out    = edge_q;

endmodule

// File: tb/tb_result_1.sv
// Directed bench for result_1 with hand-computed expected magnitudes.
module tb_result_1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [10:0] gx_out_1;
    logic [10:0] gy_out_1;
    logic [7:0]  final_out_1;
    logic        out_valid;
    logic        edge_out;

    int n_tests = 0;
    int n_fail  = 0;

    result_1 dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .gx_out_1   (gx_out_1),
        .gy_out_1   (gy_out_1),
        .final_out_1(final_out_1),
        .out_valid  (out_valid),
        .edge_out   (edge_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs on the falling edge, then settle just past the next rising edge.
    task automatic step(input logic rst, input logic vld, input int gx, input int gy);
        @(negedge clk);
        reset    = rst;
        in_valid = vld;
        gx_out_1 = gx[10:0];
        gy_out_1 = gy[10:0];
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int v, input int o, input int e);
        check({tag, ".valid"}, int'(out_valid), v);
        check({tag, ".out"},   int'(final_out_1), o);
        check({tag, ".edge"},  int'(edge_out), e);
    endtask

    localparam int NV = 14;
    int vgx  [NV] = '{ 200, -262, -1024, -30, 100, 100, 0, 255, -128, 128,  10, -60, 3, -127};
    int vgy  [NV] = '{ 112,  136, -1024,  20,  27,  28, 0,   0, -128, 127,  -5,  70, 4,    0};
    int vout [NV] = '{ 255,  255,   255,  50, 127, 128, 0, 255,  255, 255,  15, 130, 7,  127};
    int vedge[NV] = '{   1,    1,     1,   0,   0,   1, 0,   1,    1,   1,   0,   1, 0,    0};

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        gx_out_1 = 11'd50;
        gy_out_1 = 11'd50;

        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 50, 50);
            check_out($sformatf("reset%0d", i), 0, 0, 0);
        end

        // Back-to-back valid pixels, one result per cycle.
        for (int i = 0; i < NV; i++) begin
            step(1'b0, 1'b1, vgx[i], vgy[i]);
            check_out($sformatf("vec%0d", i), 1, vout[i], vedge[i]);
        end

        step(1'b0, 1'b0, 500, 0);
        check_out("hold", 0, 127, 0);

        @(negedge clk);
        in_valid = 1'b0;
        gx_out_1 = 11'bx;
        gy_out_1 = 11'bx;
        @(posedge clk);
        #1;
        check_out("hold_x", 0, 127, 0);

        step(1'b0, 1'b1, 200, 0);
        check_out("restart", 1, 200, 1);

        step(1'b1, 1'b1, 300, 300);
        check_out("mid_reset", 0, 0, 0);

        step(1'b0, 1'b1, -50, -50);
        check_out("post_reset", 1, 100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
